mc_main_ctrl: RTL and testbench

- Multi-cycle MIPS main control FSM.
- Sequences the shared datapath (PC, memory, IR, register file, ALU) one instruction at a time.
- Drives AluOp into the ALU control decoder and consumes its JR flag.
- Adds a memory ready handshake and a bounded wait timeout.
- Sits between the instruction register opcode field and all datapath mux/strobe controls.

---
 rtl/mips_ctrl_pkg.sv | 43 ++++
 rtl/mc_wait_timer.sv | 33 +++
 rtl/mc_main_ctrl.sv | 177 +++++++++++++++++
 tb/tb_mc_main_ctrl.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS main control FSM.
// Opcodes, ALU/mux selects and the state enum live here.
package mips_ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_J     = 6'h02;

  localparam logic [1:0] ALUOP_ADD  = 2'b00;
  localparam logic [1:0] ALUOP_SUB  = 2'b01;
  localparam logic [1:0] ALUOP_FUNC = 2'b10;
  localparam logic [1:0] ALUOP_ORI  = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;
  localparam logic [1:0] PCSRC_REGA   = 2'b11;

  localparam logic [1:0] SRCB_REGB  = 2'b00;
  localparam logic [1:0] SRCB_FOUR  = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_IMMSH = 2'b11;

  typedef enum logic [3:0] {
    IDLE   = 4'd0,
    FETCH  = 4'd1,
    DECODE = 4'd2,
    MEMADR = 4'd3,
    MEMRD  = 4'd4,
    MEMWB  = 4'd5,
    MEMWR  = 4'd6,
    REX    = 4'd7,
    RWB    = 4'd8,
    BEQ    = 4'd9,
    ORIEX  = 4'd10,
    ORIWB  = 4'd11,
    JMP    = 4'd12
  } state_e;

endpackage

// File: rtl/mc_wait_timer.sv
// Counts consecutive stalled cycles on mem_ready and flags
// the abort cycle once the count reaches TIMEOUT.
module mc_wait_timer #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic waiting,
  input  logic mem_ready,
  output logic expired
);

  localparam logic [7:0] LIMIT = 8'(TIMEOUT);

  logic [7:0] cnt_q;
  logic [7:0] cnt_d;
  logic       stall;

  assign stall   = waiting && !mem_ready;
  assign expired = stall && (cnt_q == LIMIT);

  // Any exit from the wait (completion, abort, other state) clears.
  always_comb begin
    cnt_d = 8'd0;
    if (stall && !expired) cnt_d = cnt_q + 8'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) cnt_q <= 8'd0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/mc_main_ctrl.sv
// Multi-cycle MIPS main control FSM with memory ready
// handshake and bounded wait timeout.
module mc_main_ctrl
  import mips_ctrl_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] Opcode,
  input  logic       JR,
  input  logic       mem_ready,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       MemtoReg,
  output logic       RegDst,
  output logic       RegWrite,
  output logic       AluSrcA,
  output logic [1:0] AluSrcB,
  output logic [1:0] AluOp,
  output logic [1:0] PCSource,
  output logic       illegal,
  output logic       mem_timeout,
  output logic [3:0] state
);

  state_e state_q;
  state_e state_d;
  logic   waiting;
  logic   expired;

  assign waiting = (state_q == FETCH) || (state_q == MEMRD) ||
                   (state_q == MEMWR);
  assign state   = state_q;

  mc_wait_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk       (clk),
    .reset     (reset),
    .waiting   (waiting),
    .mem_ready (mem_ready),
    .expired   (expired)
  );

  always_comb begin
    state_d     = state_q;
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    IRWrite     = 1'b0;
    MemtoReg    = 1'b0;
    RegDst      = 1'b0;
    RegWrite    = 1'b0;
    AluSrcA     = 1'b0;
    AluSrcB     = SRCB_REGB;
    AluOp       = ALUOP_ADD;
    PCSource    = PCSRC_ALU;
    illegal     = 1'b0;
    mem_timeout = 1'b0;
    unique case (state_q)
      IDLE: state_d = FETCH;
      FETCH: begin
        MemRead = 1'b1;
        AluSrcB = SRCB_FOUR;
        IRWrite = mem_ready;
        PCWrite = mem_ready;
        if (mem_ready) state_d = DECODE;
      end
      DECODE: begin
        AluSrcB = SRCB_IMMSH;
        unique case (Opcode)
          OP_LW, OP_SW: state_d = MEMADR;
          OP_RTYPE:     state_d = REX;
          OP_BEQ:       state_d = BEQ;
          OP_ORI:       state_d = ORIEX;
          OP_J:         state_d = JMP;
          default: begin
            state_d = FETCH;
            illegal = 1'b1;
          end
        endcase
      end
      MEMADR: begin
        AluSrcA = 1'b1;
        AluSrcB = SRCB_IMM;
        state_d = (Opcode == OP_LW) ? MEMRD : MEMWR;
      end
      MEMRD: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
        if (mem_ready) state_d = MEMWB;
      end
      MEMWB: begin
        RegWrite = 1'b1;
        MemtoReg = 1'b1;
        state_d  = FETCH;
      end
      MEMWR: begin
        MemWrite = 1'b1;
        IorD     = 1'b1;
        if (mem_ready) state_d = FETCH;
      end
      REX: begin
        AluSrcA = 1'b1;
        AluOp   = ALUOP_FUNC;
        if (JR) begin
          PCSource = PCSRC_REGA;
          PCWrite  = 1'b1;
          state_d  = FETCH;
        end else begin
          state_d = RWB;
        end
      end
      RWB: begin
        RegWrite = 1'b1;
        RegDst   = 1'b1;
        AluOp    = ALUOP_FUNC;
        state_d  = FETCH;
      end
      BEQ: begin
        AluSrcA     = 1'b1;
        AluOp       = ALUOP_SUB;
        PCWriteCond = 1'b1;
        PCSource    = PCSRC_ALUOUT;
        state_d     = FETCH;
      end
      ORIEX: begin
        AluSrcA = 1'b1;
        AluSrcB = SRCB_IMM;
        AluOp   = ALUOP_ORI;
        state_d = ORIWB;
      end
      ORIWB: begin
        AluSrcA  = 1'b1;
        AluSrcB  = SRCB_IMM;
        AluOp    = ALUOP_ORI;
        RegWrite = 1'b1;
        state_d  = FETCH;
      end
      JMP: begin
        PCWrite  = 1'b1;
        PCSource = PCSRC_JUMP;
        state_d  = FETCH;
      end
      default: state_d = IDLE;
    endcase
    // Abort quiets every strobe and restarts the fetch.
    if (expired) begin
      PCWrite     = 1'b0;
      PCWriteCond = 1'b0;
      IorD        = 1'b0;
      MemRead     = 1'b0;
      MemWrite    = 1'b0;
      IRWrite     = 1'b0;
      MemtoReg    = 1'b0;
      RegDst      = 1'b0;
      RegWrite    = 1'b0;
      AluSrcA     = 1'b0;
      AluSrcB     = SRCB_REGB;
      AluOp       = ALUOP_ADD;
      PCSource    = PCSRC_ALU;
      mem_timeout = 1'b1;
      state_d     = FETCH;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

endmodule

// File: tb/tb_mc_main_ctrl.sv
// Directed bench for mc_main_ctrl with TIMEOUT=4.
// Control bundle: PW PWC IorD MR MW IRW M2R RD RW SA|SB|AO|PS|ill|to
module tb_mc_main_ctrl;
  import mips_ctrl_pkg::*;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [5:0] Opcode = 6'h23;
  logic       JR = 1'b0;
  logic       mem_ready = 1'b1;
  logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite;
  logic       IRWrite, MemtoReg, RegDst, RegWrite, AluSrcA;
  logic [1:0] AluSrcB, AluOp, PCSource;
  logic       illegal, mem_timeout;
  logic [3:0] state;
  logic [17:0] ctl;

  int checks = 0;
  int errors = 0;

  localparam logic [17:0] C_IDLE  = 18'b0000000000_00_00_00_0_0;
  localparam logic [17:0] C_FET1  = 18'b1001010000_01_00_00_0_0;
  localparam logic [17:0] C_FET0  = 18'b0001000000_01_00_00_0_0;
  localparam logic [17:0] C_DEC   = 18'b0000000000_11_00_00_0_0;
  localparam logic [17:0] C_DECIL = 18'b0000000000_11_00_00_1_0;
  localparam logic [17:0] C_MADR  = 18'b0000000001_10_00_00_0_0;
  localparam logic [17:0] C_MRD   = 18'b0011000000_00_00_00_0_0;
  localparam logic [17:0] C_MWB   = 18'b0000001010_00_00_00_0_0;
  localparam logic [17:0] C_MWR   = 18'b0010100000_00_00_00_0_0;
  localparam logic [17:0] C_REXJ  = 18'b1000000001_00_10_11_0_0;
  localparam logic [17:0] C_REX   = 18'b0000000001_00_10_00_0_0;
  localparam logic [17:0] C_RWB   = 18'b0000000110_00_10_00_0_0;
  localparam logic [17:0] C_BEQ   = 18'b0100000001_00_01_01_0_0;
  localparam logic [17:0] C_ORIEX = 18'b0000000001_10_11_00_0_0;
  localparam logic [17:0] C_ORIWB = 18'b0000000011_10_11_00_0_0;
  localparam logic [17:0] C_JMP   = 18'b1000000000_00_00_10_0_0;
  localparam logic [17:0] C_TO    = 18'b0000000000_00_00_00_0_1;

  assign ctl = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite,
                IRWrite, MemtoReg, RegDst, RegWrite, AluSrcA,
                AluSrcB, AluOp, PCSource, illegal, mem_timeout};

  mc_main_ctrl #(.TIMEOUT(4)) dut (
    .clk(clk), .reset(reset), .Opcode(Opcode), .JR(JR),
    .mem_ready(mem_ready), .PCWrite(PCWrite),
    .PCWriteCond(PCWriteCond), .IorD(IorD), .MemRead(MemRead),
    .MemWrite(MemWrite), .IRWrite(IRWrite), .MemtoReg(MemtoReg),
    .RegDst(RegDst), .RegWrite(RegWrite), .AluSrcA(AluSrcA),
    .AluSrcB(AluSrcB), .AluOp(AluOp), .PCSource(PCSource),
    .illegal(illegal), .mem_timeout(mem_timeout), .state(state)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    mem_ready = 1'b1;
    Opcode = OP_LW;
    step();
    step();
    reset = 1'b0;
    checks++;
    if (state !== 4'd0) begin
      errors++;
      $display("FAIL reset_state got %0d exp 0", state);
    end
    checks++;
    if (ctl !== C_IDLE) begin
      errors++;
      $display("FAIL reset_ctl got %b exp %b", ctl, C_IDLE);
    end
  endtask

  task automatic test_lw();
    state_e      es [6] = '{FETCH, DECODE, MEMADR, MEMRD, MEMWB, FETCH};
    logic [17:0] ec [6] = '{C_FET1, C_DEC, C_MADR, C_MRD, C_MWB, C_FET1};
    for (int i = 0; i < 6; i++) begin
      step();
      checks++;
      if (state !== 4'(es[i])) begin
        errors++;
        $display("FAIL lw_state[%0d] got %0d exp %0d", i, state, es[i]);
      end
      checks++;
      if (ctl !== ec[i]) begin
        errors++;
        $display("FAIL lw_ctl[%0d] got %b exp %b", i, ctl, ec[i]);
      end
    end
  endtask

  task automatic test_rtype();
    state_e      es [7] = '{DECODE, REX, FETCH, DECODE, REX, RWB, FETCH};
    logic [17:0] ec [7] = '{C_DEC, C_REXJ, C_FET1, C_DEC, C_REX,
                            C_RWB, C_FET1};
    Opcode = OP_RTYPE;
    JR = 1'b1;
    for (int i = 0; i < 7; i++) begin
      if (i == 3) JR = 1'b0;
      step();
      checks++;
      if (state !== 4'(es[i])) begin
        errors++;
        $display("FAIL rt_state[%0d] got %0d exp %0d", i, state, es[i]);
      end
      checks++;
      if (ctl !== ec[i]) begin
        errors++;
        $display("FAIL rt_ctl[%0d] got %b exp %b", i, ctl, ec[i]);
      end
    end
  endtask

  task automatic test_sw_wait();
    Opcode = OP_SW;
    step();
    step();
    mem_ready = 1'b0;
    step();
    for (int i = 0; i < 4; i++) begin
      if (i == 3) mem_ready = 1'b1;
      #1;
      checks++;
      if (state !== 4'(MEMWR) || ctl !== C_MWR) begin
        errors++;
        $display("FAIL sw_wait[%0d] got %0d/%b exp %0d/%b",
                 i, state, ctl, MEMWR, C_MWR);
      end
      step();
    end
    checks++;
    if (state !== 4'(FETCH) || ctl !== C_FET1) begin
      errors++;
      $display("FAIL sw_done got %0d/%b exp %0d/%b",
               state, ctl, FETCH, C_FET1);
    end
  endtask

  task automatic test_timeout();
    logic [17:0] exp_c;
    mem_ready = 1'b0;
    #1;
    for (int r = 0; r < 2; r++) begin
      for (int k = 1; k <= 5; k++) begin
        exp_c = (k == 5) ? C_TO : C_FET0;
        checks++;
        if (state !== 4'(FETCH) || ctl !== exp_c) begin
          errors++;
          $display("FAIL timeout[%0d.%0d] got %0d/%b exp %0d/%b",
                   r, k, state, ctl, FETCH, exp_c);
        end
        step();
      end
    end
    mem_ready = 1'b1;
    #1;
    checks++;
    if (state !== 4'(FETCH) || ctl !== C_FET1) begin
      errors++;
      $display("FAIL timeout_resume got %0d/%b exp %0d/%b",
               state, ctl, FETCH, C_FET1);
    end
  endtask

  task automatic test_illegal();
    Opcode = 6'h3F;
    step();
    checks++;
    if (state !== 4'(DECODE) || ctl !== C_DECIL) begin
      errors++;
      $display("FAIL illegal_dec got %0d/%b exp %0d/%b",
               state, ctl, DECODE, C_DECIL);
    end
    step();
    checks++;
    if (state !== 4'(FETCH) || ctl !== C_FET1) begin
      errors++;
      $display("FAIL illegal_next got %0d/%b exp %0d/%b",
               state, ctl, FETCH, C_FET1);
    end
  endtask

  task automatic test_reset_mid();
    Opcode = OP_LW;
    step();
    step();
    mem_ready = 1'b0;
    step();
    step();
    checks++;
    if (state !== 4'(MEMRD) || ctl !== C_MRD) begin
      errors++;
      $display("FAIL rmid_wait got %0d/%b exp %0d/%b",
               state, ctl, MEMRD, C_MRD);
    end
    reset = 1'b1;
    step();
    reset = 1'b0;
    mem_ready = 1'b1;
    #1;
    checks++;
    if (state !== 4'(IDLE) || ctl !== C_IDLE) begin
      errors++;
      $display("FAIL rmid_idle got %0d/%b exp 0/%b", state, ctl, C_IDLE);
    end
    step();
    checks++;
    if (state !== 4'(FETCH) || ctl !== C_FET1) begin
      errors++;
      $display("FAIL rmid_fetch got %0d/%b exp %0d/%b",
               state, ctl, FETCH, C_FET1);
    end
    step();
    checks++;
    if (state !== 4'(DECODE)) begin
      errors++;
      $display("FAIL rmid_dec got %0d exp %0d", state, DECODE);
    end
    step();
    step();
    step();
    step();
  endtask

  task automatic test_back_to_back();
    logic [5:0]  op [10] = '{6'h04, 6'h04, 6'h04, 6'h0D, 6'h0D,
                             6'h0D, 6'h0D, 6'h02, 6'h02, 6'h02};
    state_e      es [10] = '{DECODE, BEQ, FETCH, DECODE, ORIEX, ORIWB,
                             FETCH, DECODE, JMP, FETCH};
    logic [17:0] ec [10] = '{C_DEC, C_BEQ, C_FET1, C_DEC, C_ORIEX,
                             C_ORIWB, C_FET1, C_DEC, C_JMP, C_FET1};
    for (int i = 0; i < 10; i++) begin
      Opcode = op[i];
      step();
      checks++;
      if (state !== 4'(es[i]) || ctl !== ec[i]) begin
        errors++;
        $display("FAIL b2b[%0d] got %0d/%b exp %0d/%b",
                 i, state, ctl, es[i], ec[i]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_lw();
    test_rtype();
    test_sw_wait();
    test_timeout();
    test_illegal();
    test_reset_mid();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
